binary_maxpool: RTL and testbench
=================================

# binary_maxpool

Downstream stage of the binary XNOR-convolution engine. Streams convolution result matrices out of the shared input/output SRAM, applies 2×2 stride-2 max-pooling (a bitwise OR on binary data), and writes the pooled matrices to a second SRAM. It uses the same run/busy handshake and terminator-delimited memory layout as the convolution stage, so the two can be chained by the top-level controller.

## Interface
- `ADDR_W`, 12: SRAM address width.
- `DATA_W`, 16: SRAM word width.
- `clk`  in  1: sole clock; all state changes on the rising edge.
- `reset_b`  in  1: asynchronous, active-high reset. It is asserted at 1, despite the port name.
- `pool_run`  in  1: start request; sampled only in IDLE.
- `pool_busy`  out  1: high from the cycle after an accepted run until the terminator write completes.
- `pool_err`  out  1: sticky; set on an invalid header; cleared by the next accepted run.
- `pool_sram_read_address`  out  ADDR_W: source SRAM read address, registered.
- `sram_pool_read_data`  in  DATA_W: source data, valid 1 cycle after its address.
- `pool_sram_write_address`  out  ADDR_W: destination address, registered.
- `pool_sram_write_data`  out  DATA_W: destination data, registered.
- `pool_sram_write_enable`  out  1: one-cycle write strobe per output word.

## Operation
- Source layout, starting at address 0:
  - Each record is a header word N followed by N row words.
  - N ∈ {8, 10, 14}. Row bit c = pixel column c. Bits ≥ N are ignored.
  - Header 16'h00FF terminates the list.
- Destination layout, starting at address 0:
  - Per input record: header N/2, then N/2 pooled rows.
  - After the last record: terminator 16'h00FF.
- Pooling rule:
  - Out row i, bit j = A[2j] | A[2j+1] | B[2j] | B[2j+1], where A = input row 2i and B = input row 2i+1.
  - Bits ≥ N/2 are written as 0.
- FSM states:
  - IDLE → HDR on `pool_run`.
  - HDR (decode header word):
    - Valid N → ROW_A.
    - 16'h00FF → TERM.
    - Any other value → TERM with `pool_err` set.
  - ROW_A: latch row A → ROW_B.
  - ROW_B: latch row B, compute, write.
    - → ROW_A while rows remain.
    - → HDR after row N−1.
  - TERM: write 16'h00FF → IDLE.
- Counters:
  - Read address increments by 1 for every accepted word.
  - Write address increments by 1 per strobe.
  - Row counter counts 0..N−1, compared against the latched N.
- Arithmetic: all addresses wrap modulo 2^ADDR_W with no saturation.
- `pool_run` asserted while busy is ignored; no restart or queueing.
- Reset mid-operation: every register returns to its reset value immediately and any pending write is dropped. Output memory contents are left as-is.
- Reset values: `pool_busy` = 0, `pool_err` = 0, `pool_sram_write_enable` = 0, both addresses = 0, `pool_sram_write_data` = 0, FSM = IDLE.

## Timing
- Start sequence:
  - Cycle 0: `pool_run` = 1 in IDLE.
  - Cycle 1: `pool_busy` = 1 and read address = 0.
  - Cycle 2: header data arrives.
- Reads issue one per cycle, back-to-back; input throughput is 1 word/cycle.
- Each non-terminator word arriving in cycle t drives at most one write, visible in cycle t+1 (write enable, address and data all registered together).
  - Valid header → write of N/2.
  - Every second row → pooled write.
- Terminator arriving in cycle t:
  - Write of 16'h00FF in cycle t+1.
  - `pool_busy` = 0 in cycle t+2.
  - At most one speculative read past the terminator address is issued; the read address then holds.
- Cycle count: for one record of size N plus terminator, busy lasts N+4 cycles.
- Write strobes are never adjacent to a ROW_A cycle's data; at most one write per 2 input cycles inside a record.

## Structure
- Shared package `pool_pkg`:
  - `TERM_WORD` = 16'h00FF.
  - Legal dimension constants 8, 10 and 14.
  - FSM state enum.
  - The same terminator constant reused by the convolution stage.
- Sub-module `pool_or_row`: purely combinational. Takes two 16-bit rows and N and returns one 16-bit pooled word. It is instantiated once.
- Everything else (FSM, counters, registered outputs) stays in `binary_maxpool`.

## Test plan
- 8×8 all-ones record + terminator → writes in order: 4, then 16'h000F ×4, then 16'h00FF. Busy for 12 cycles.
- 14×14 checkerboard (rows alternate 16'h1555 / 16'h2AAA) → header 7, then every row = 16'h007F.
- Back-to-back records 10 then 8 (single pixel set at row 9, col 9 in the first) → pooled row 4 of the first = 16'h0010. The second header lands at write address 6.
- Source word 0 = 16'h00FF → single write of 16'h00FF at address 0; `pool_err` = 0; busy falls at cycle 4.
- Header 16'h000C (illegal 12) → immediate terminator write, `pool_err` = 1. `pool_err` is cleared in the cycle after the next `pool_run`.
- `reset_b` pulsed mid-record, then a fresh run → no writes after reset. The rerun output matches the golden model from address 0, and `pool_run` pulses during busy have no effect.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared definitions for the binary max-pool stage: terminator word, legal
// matrix sizes and the controller state encoding.
package pool_pkg;

  localparam logic [15:0] TERM_WORD = 16'h00FF;

  localparam logic [4:0] DIM_8  = 5'd8;
  localparam logic [4:0] DIM_10 = 5'd10;
  localparam logic [4:0] DIM_14 = 5'd14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ROW_A,
    ST_ROW_B,
    ST_TERM
  } pool_state_e;

  function automatic logic is_legal_dim(input logic [15:0] hdr);
    return (hdr == {11'd0, DIM_8}) || (hdr == {11'd0, DIM_10}) ||
           (hdr == {11'd0, DIM_14});
  endfunction

endpackage

// File: rtl/binary_maxpool_if.sv
// Run/busy handshake plus source-read and destination-write SRAM ports of the
// max-pool stage. The slave modport is the pool itself.
interface binary_maxpool_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              pool_run;
  logic              pool_busy;
  logic              pool_err;
  logic [ADDR_W-1:0] pool_sram_read_address;
  logic [DATA_W-1:0] sram_pool_read_data;
  logic [ADDR_W-1:0] pool_sram_write_address;
  logic [DATA_W-1:0] pool_sram_write_data;
  logic              pool_sram_write_enable;

  modport master (
    output pool_run, sram_pool_read_data,
    input  pool_busy, pool_err, pool_sram_read_address,
           pool_sram_write_address, pool_sram_write_data, pool_sram_write_enable
  );

  modport slave (
    input  pool_run, sram_pool_read_data,
    output pool_busy, pool_err, pool_sram_read_address,
           pool_sram_write_address, pool_sram_write_data, pool_sram_write_enable
  );
endinterface

// File: rtl/pool_or_row.sv
// Combinational 2x2 OR-pool of two adjacent binary rows; output columns at or
// beyond N/2 are forced to zero.
module pool_or_row (
  input  logic [15:0] row_a,
  input  logic [15:0] row_b,
  input  logic [4:0]  n,
  output logic [15:0] pooled
);

  always_comb begin
    pooled = '0;
    for (int j = 0; j < 8; j++) begin
      if (j < (int'(n) >> 1)) begin
        pooled[j] = row_a[2*j] | row_a[2*j+1] | row_b[2*j] | row_b[2*j+1];
      end
    end
  end

endmodule

// File: rtl/binary_maxpool.sv
// Streams terminator-delimited binary matrices from the source SRAM, applies
// 2x2 stride-2 max-pooling and writes the pooled records to the destination SRAM.
module binary_maxpool
  import pool_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic             clk,
  input  logic             reset_b,
  binary_maxpool_if.slave  bus
);

  pool_state_e       state_q, state_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              vld_q, vld_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] row_a_q, row_a_d;
  logic [4:0]        n_q, n_d;
  logic [4:0]        cnt_q, cnt_d;

  logic [DATA_W-1:0] rd_data;
  logic [15:0]       pooled;
  logic              issue;
  logic              do_write;
  logic [DATA_W-1:0] wword;

  assign rd_data = bus.sram_pool_read_data;

  pool_or_row u_or_row (
    .row_a  (row_a_q[15:0]),
    .row_b  (rd_data[15:0]),
    .n      (n_q),
    .pooled (pooled)
  );

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    err_d     = err_q;
    vld_d     = 1'b0;
    we_d      = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wcnt_d    = wcnt_q;
    wr_data_d = wr_data_q;
    row_a_d   = row_a_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    issue     = 1'b0;
    do_write  = 1'b0;
    wword     = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.pool_run) begin
          state_d   = ST_HDR;
          busy_d    = 1'b1;
          err_d     = 1'b0;
          rd_addr_d = '0;
          wcnt_d    = '0;
        end
      end
      ST_HDR: begin
        issue = 1'b1;
        // The first HDR cycle after a run has no data yet; only the read is issued.
        if (vld_q) begin
          if (is_legal_dim(rd_data[15:0])) begin
            n_d      = rd_data[4:0];
            cnt_d    = '0;
            state_d  = ST_ROW_A;
            do_write = 1'b1;
            wword    = DATA_W'(rd_data[4:1]);
          end else begin
            err_d    = (rd_data[15:0] != TERM_WORD);
            state_d  = ST_TERM;
            issue    = 1'b0;
            do_write = 1'b1;
            wword    = DATA_W'(TERM_WORD);
          end
        end
      end
      ST_ROW_A: begin
        issue   = 1'b1;
        row_a_d = rd_data;
        cnt_d   = cnt_q + 5'd1;
        state_d = ST_ROW_B;
      end
      ST_ROW_B: begin
        issue    = 1'b1;
        do_write = 1'b1;
        wword    = DATA_W'(pooled);
        cnt_d    = cnt_q + 5'd1;
        state_d  = (cnt_q == n_q - 5'd1) ? ST_HDR : ST_ROW_A;
      end
      ST_TERM: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      rd_addr_d = rd_addr_q + 1'b1;
      vld_d     = 1'b1;
    end
    if (do_write) begin
      we_d      = 1'b1;
      wr_addr_d = wcnt_q;
      wr_data_d = wword;
      wcnt_d    = wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      vld_q     <= 1'b0;
      we_q      <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wcnt_q    <= '0;
      wr_data_q <= '0;
      row_a_q   <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      vld_q     <= vld_d;
      we_q      <= we_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wcnt_q    <= wcnt_d;
      wr_data_q <= wr_data_d;
      row_a_q   <= row_a_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.pool_busy               = busy_q;
  assign bus.pool_err                = err_q;
  assign bus.pool_sram_read_address  = rd_addr_q;
  assign bus.pool_sram_write_address = wr_addr_q;
  assign bus.pool_sram_write_data    = wr_data_q;
  assign bus.pool_sram_write_enable  = we_q;

endmodule

// File: tb/tb_binary_maxpool.sv
// Randomized self-checking bench for binary_maxpool against a pixel-level
// pooling model of the source memory image.
module tb_binary_maxpool;

  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset_b = 1'b1;
  always #5 clk = ~clk;

  binary_maxpool_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  binary_maxpool #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus)
  );

  logic [15:0] src [0:4095];
  always @(posedge clk) bus.sram_pool_read_data <= src[bus.pool_sram_read_address];

  int errors = 0;
  int checks = 0;

  int          obs_a[$];
  logic [15:0] obs_d[$];
  int          obs_c[$];
  int          obs_busy;
  logic        obs_busy1, obs_err1, obs_err_end, obs_timeout;
  logic [11:0] obs_ra1, obs_ra_end;

  int          exp_a[$];
  logic [15:0] exp_d[$];
  int          exp_c[$];
  int          exp_busy;
  logic        exp_err;
  int          exp_ra_end;

  task automatic clear_src();
    for (int i = 0; i < 4096; i++) src[i] = 16'h0000;
  endtask

  // Walks the source image record by record; pooled bit = OR of a 2x2 pixel block.
  // Each triggering word at source address p arrives in cycle p+2, its write shows in p+3.
  task automatic build_model();
    int p;
    int w;
    int n;
    logic [15:0] h;
    logic [15:0] word;
    logic [15:0] row;
    p = 0;
    w = 0;
    exp_a.delete(); exp_d.delete(); exp_c.delete();
    exp_err = 1'b0;
    for (int rec = 0; rec < 200; rec++) begin
      h = src[p];
      if (h == 16'd8 || h == 16'd10 || h == 16'd14) begin
        n = int'(h);
        exp_a.push_back(w); exp_d.push_back(16'(n / 2)); exp_c.push_back(p + 3); w++;
        for (int i = 0; i < n / 2; i++) begin
          word = 16'h0000;
          for (int j = 0; j < n / 2; j++)
            for (int r = 0; r < 2; r++) begin
              row = src[p + 1 + 2 * i + r];
              if (row[2 * j] || row[2 * j + 1]) word[j] = 1'b1;
            end
          exp_a.push_back(w); exp_d.push_back(word); exp_c.push_back(p + 1 + 2 * i + 1 + 3); w++;
        end
        p += n + 1;
      end else begin
        exp_err = (h != 16'h00FF);
        exp_a.push_back(w); exp_d.push_back(16'h00FF); exp_c.push_back(p + 3);
        exp_busy   = p + 3;
        exp_ra_end = p + 1;
        break;
      end
    end
  endtask

  // Issues one run and records every write with the cycle (relative to the run) it was visible.
  task automatic run_dut(input bit ghosts);
    int k;
    obs_a.delete(); obs_d.delete(); obs_c.delete();
    obs_busy = 0;
    obs_timeout = 1'b0;
    @(negedge clk); bus.pool_run = 1'b1;
    @(negedge clk); bus.pool_run = 1'b0;
    k = 1;
    while (1) begin
      if (k == 1) begin
        obs_busy1 = bus.pool_busy;
        obs_ra1   = bus.pool_sram_read_address;
        obs_err1  = bus.pool_err;
      end
      if (bus.pool_sram_write_enable) begin
        obs_a.push_back(int'(bus.pool_sram_write_address));
        obs_d.push_back(bus.pool_sram_write_data);
        obs_c.push_back(k);
      end
      if (!bus.pool_busy) break;
      obs_busy++;
      if (k > 3000) begin
        obs_timeout = 1'b1;
        break;
      end
      bus.pool_run = ghosts ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      k++;
    end
    bus.pool_run = 1'b0;
    obs_err_end = bus.pool_err;
    obs_ra_end  = bus.pool_sram_read_address;
  endtask

  task automatic test_reset();
    bus.pool_run = 1'b0;
    reset_b = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.pool_busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", bus.pool_busy); end
    checks++; if (bus.pool_err !== 1'b0) begin errors++; $display("FAIL reset err: got %b want 0", bus.pool_err); end
    checks++; if (bus.pool_sram_write_enable !== 1'b0) begin errors++; $display("FAIL reset we: got %b want 0", bus.pool_sram_write_enable); end
    checks++; if (bus.pool_sram_read_address !== 12'd0) begin errors++; $display("FAIL reset raddr: got %h want 0", bus.pool_sram_read_address); end
    checks++; if (bus.pool_sram_write_address !== 12'd0) begin errors++; $display("FAIL reset waddr: got %h want 0", bus.pool_sram_write_address); end
    checks++; if (bus.pool_sram_write_data !== 16'd0) begin errors++; $display("FAIL reset wdata: got %h want 0", bus.pool_sram_write_data); end
    reset_b = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ones8();
    clear_src();
    src[0] = 16'd8;
    for (int i = 1; i <= 8; i++) src[i] = 16'hFFFF;
    src[9] = 16'h00FF;
    build_model();
    run_dut(1'b0);
    checks++; if (obs_a.size() != exp_a.size()) begin errors++; $display("FAIL ones8 count: got %0d want %0d", obs_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] != exp_a[i] || obs_d[i] !== exp_d[i] || obs_c[i] != exp_c[i]) begin
        errors++; $display("FAIL ones8 write%0d: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", i, obs_a[i], obs_d[i], obs_c[i], exp_a[i], exp_d[i], exp_c[i]);
      end
    end
    checks++; if (obs_busy != 12) begin errors++; $display("FAIL ones8 busy: got %0d want 12", obs_busy); end
    checks++; if (obs_a.size() > 1 && obs_d[1] !== 16'h000F) begin errors++; $display("FAIL ones8 row0: got %h want 000F", obs_d[1]); end
    checks++; if (obs_err_end !== 1'b0) begin errors++; $display("FAIL ones8 err: got %b want 0", obs_err_end); end
  endtask

  task automatic test_checker14();
    clear_src();
    src[0] = 16'd14;
    for (int i = 0; i < 14; i++)
      src[1 + i] = ((i % 2) ? 16'h2AAA : 16'h1555) | {2'($urandom), 14'h0};
    src[15] = 16'h00FF;
    build_model();
    run_dut(1'b0);
    checks++; if (obs_a.size() != exp_a.size()) begin errors++; $display("FAIL chk14 count: got %0d want %0d", obs_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] != exp_a[i] || obs_d[i] !== exp_d[i] || obs_c[i] != exp_c[i]) begin
        errors++; $display("FAIL chk14 write%0d: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", i, obs_a[i], obs_d[i], obs_c[i], exp_a[i], exp_d[i], exp_c[i]);
      end
    end
    for (int i = 1; i <= 7 && i < obs_d.size(); i++) begin
      checks++; if (obs_d[i] !== 16'h007F) begin errors++; $display("FAIL chk14 row%0d: got %h want 007F", i - 1, obs_d[i]); end
    end
    checks++; if (obs_busy != exp_busy) begin errors++; $display("FAIL chk14 busy: got %0d want %0d", obs_busy, exp_busy); end
  endtask

  task automatic test_back_to_back();
    clear_src();
    src[0] = 16'd10;
    src[10] = 16'h0200;
    src[11] = 16'd8;
    for (int i = 12; i < 20; i++) src[i] = 16'($urandom);
    src[20] = 16'h00FF;
    build_model();
    run_dut(1'b0);
    checks++; if (obs_a.size() != exp_a.size()) begin errors++; $display("FAIL b2b count: got %0d want %0d", obs_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] != exp_a[i] || obs_d[i] !== exp_d[i] || obs_c[i] != exp_c[i]) begin
        errors++; $display("FAIL b2b write%0d: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", i, obs_a[i], obs_d[i], obs_c[i], exp_a[i], exp_d[i], exp_c[i]);
      end
    end
    checks++; if (obs_d.size() < 7 || obs_d[5] !== 16'h0010 || obs_a[5] != 5) begin errors++; $display("FAIL b2b row4: got size=%0d want d=0010 at a=5", obs_d.size()); end
    checks++; if (obs_d.size() < 7 || obs_a[6] != 6 || obs_d[6] !== 16'd4) begin errors++; $display("FAIL b2b hdr2: got size=%0d want d=0004 at a=6", obs_d.size()); end
    checks++; if (obs_busy != exp_busy) begin errors++; $display("FAIL b2b busy: got %0d want %0d", obs_busy, exp_busy); end
  endtask

  task automatic test_term_only();
    clear_src();
    src[0] = 16'h00FF;
    run_dut(1'b0);
    checks++; if (obs_busy1 !== 1'b1) begin errors++; $display("FAIL term busy1: got %b want 1", obs_busy1); end
    checks++; if (obs_ra1 !== 12'd0) begin errors++; $display("FAIL term raddr1: got %h want 0", obs_ra1); end
    checks++; if (obs_a.size() != 1 || obs_a[0] != 0 || obs_d[0] !== 16'h00FF || obs_c[0] != 3) begin errors++; $display("FAIL term write: got n=%0d want one 00FF at a=0 c=3", obs_a.size()); end
    checks++; if (obs_busy != 3) begin errors++; $display("FAIL term busy: got %0d want 3", obs_busy); end
    checks++; if (obs_err_end !== 1'b0) begin errors++; $display("FAIL term err: got %b want 0", obs_err_end); end
    checks++; if (obs_ra_end !== 12'd1) begin errors++; $display("FAIL term raddr_end: got %h want 001", obs_ra_end); end
  endtask

  task automatic test_illegal_header();
    clear_src();
    src[0] = 16'h000C;
    build_model();
    run_dut(1'b0);
    checks++; if (obs_a.size() != 1 || obs_a[0] != 0 || obs_d[0] !== 16'h00FF || obs_c[0] != exp_c[0]) begin errors++; $display("FAIL illegal write: got n=%0d want one 00FF at a=0", obs_a.size()); end
    checks++; if (obs_err_end !== 1'b1 || exp_err !== 1'b1) begin errors++; $display("FAIL illegal err: got %b want 1", obs_err_end); end
    repeat (2) @(negedge clk);
    checks++; if (bus.pool_err !== 1'b1) begin errors++; $display("FAIL illegal err_sticky: got %b want 1", bus.pool_err); end
    src[0] = 16'h00FF;
    run_dut(1'b0);
    checks++; if (obs_err1 !== 1'b0) begin errors++; $display("FAIL illegal err_clear: got %b want 0", obs_err1); end
    checks++; if (obs_err_end !== 1'b0) begin errors++; $display("FAIL illegal err_after: got %b want 0", obs_err_end); end
  endtask

  task automatic load_random_list(input int nrec);
    int p;
    int n;
    clear_src();
    p = 0;
    for (int r = 0; r < nrec; r++) begin
      case ($urandom_range(0, 2))
        0: n = 8;
        1: n = 10;
        default: n = 14;
      endcase
      src[p] = 16'(n);
      for (int i = 1; i <= n; i++) src[p + i] = 16'($urandom);
      p += n + 1;
    end
    src[p] = ($urandom_range(0, 3) == 0) ? 16'h0007 : 16'h00FF;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      load_random_list($urandom_range(1, 4));
      build_model();
      run_dut(1'b1);
      checks++; if (obs_a.size() != exp_a.size()) begin errors++; $display("FAIL rand%0d count: got %0d want %0d", it, obs_a.size(), exp_a.size()); end
      for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
        checks++;
        if (obs_a[i] != exp_a[i] || obs_d[i] !== exp_d[i] || obs_c[i] != exp_c[i]) begin
          errors++; $display("FAIL rand%0d write%0d: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", it, i, obs_a[i], obs_d[i], obs_c[i], exp_a[i], exp_d[i], exp_c[i]);
        end
      end
      checks++; if (obs_busy != exp_busy) begin errors++; $display("FAIL rand%0d busy: got %0d want %0d", it, obs_busy, exp_busy); end
      checks++; if (obs_err_end !== exp_err) begin errors++; $display("FAIL rand%0d err: got %b want %b", it, obs_err_end, exp_err); end
      checks++; if (obs_ra_end !== 12'(exp_ra_end)) begin errors++; $display("FAIL rand%0d raddr_end: got %h want %h", it, obs_ra_end, 12'(exp_ra_end)); end
      checks++; if (obs_timeout !== 1'b0) begin errors++; $display("FAIL rand%0d timeout: got %b want 0", it, obs_timeout); end
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    load_random_list(3);
    if (src[44] != 16'h00FF) src[44] = 16'h00FF;
    @(negedge clk); bus.pool_run = 1'b1;
    @(negedge clk); bus.pool_run = 1'b0;
    repeat (17) @(negedge clk);
    reset_b = 1'b1;
    #1;
    checks++; if (bus.pool_busy !== 1'b0 || bus.pool_sram_write_enable !== 1'b0) begin errors++; $display("FAIL rstmid immediate: got busy=%b we=%b want 0 0", bus.pool_busy, bus.pool_sram_write_enable); end
    checks++; if (bus.pool_sram_read_address !== 12'd0 || bus.pool_sram_write_address !== 12'd0) begin errors++; $display("FAIL rstmid addr: got r=%h w=%h want 0 0", bus.pool_sram_read_address, bus.pool_sram_write_address); end
    stray = 0;
    repeat (3) begin @(negedge clk); if (bus.pool_sram_write_enable !== 1'b0) stray++; end
    reset_b = 1'b0;
    repeat (4) begin @(negedge clk); if (bus.pool_sram_write_enable !== 1'b0 || bus.pool_busy !== 1'b0) stray++; end
    checks++; if (stray != 0) begin errors++; $display("FAIL rstmid stray: got %0d want 0", stray); end
    build_model();
    run_dut(1'b1);
    checks++; if (obs_a.size() != exp_a.size()) begin errors++; $display("FAIL rstmid count: got %0d want %0d", obs_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i] != exp_a[i] || obs_d[i] !== exp_d[i] || obs_c[i] != exp_c[i]) begin
        errors++; $display("FAIL rstmid write%0d: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", i, obs_a[i], obs_d[i], obs_c[i], exp_a[i], exp_d[i], exp_c[i]);
      end
    end
    checks++; if (obs_busy != exp_busy) begin errors++; $display("FAIL rstmid busy: got %0d want %0d", obs_busy, exp_busy); end
  endtask

  initial begin
    bus.pool_run = 1'b0;
    test_reset();
    test_ones8();
    test_checker14();
    test_back_to_back();
    test_term_only();
    test_illegal_header();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
